atan_sched: RTL

Round-robin scheduler that shares one combinational `arctan` core among `NREQ` requesters. Each requester presents a signed (x, y) operand pair with a valid/ready handshake. The scheduler registers the granted operands onto the core and holds them for `SETTLE` cycles. It then captures the core's theta and returns it with a one-hot response strobe. It sits between the angle-consuming client blocks and the single `arctan` instance.

---
 rtl/atan_sched_pkg.sv | 20 ++
 rtl/atan_sched_rr_pick.sv | 34 +++
 rtl/atan_sched.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/atan_sched_pkg.sv
// Shared types and default sizing for the arctan request scheduler.
// Optional build macro used by the scheduler: ATAN_ZERO_CHK_EN.
package atan_sched_pkg;

    localparam int ATAN_NREQ   = 4;
    localparam int ATAN_W      = 32;
    localparam int ATAN_SETTLE = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } sched_state_t;

    // Width of a down-counter that must hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/atan_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
// Produces a one-hot grant, its index, and an any-request flag.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/atan_sched.sv
// Shares one combinational arctan core among NREQ requesters, round-robin.
// Optional build macro: ATAN_ZERO_CHK_EN (short-circuit the zero vector with rsp_err).
module atan_sched
    import atan_sched_pkg::*;
#(
    parameter int NREQ   = ATAN_NREQ,
    parameter int W      = ATAN_W,
    parameter int SETTLE = ATAN_SETTLE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_x,
    input  logic [NREQ*W-1:0]       req_y,
    output logic [W-1:0]            core_x,
    output logic [W-1:0]            core_y,
    input  logic [W-1:0]            core_theta,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [W-1:0]            rsp_theta,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_width(SETTLE);

    sched_state_t    state_q, state_d;
    logic [IW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    core_x_q, core_y_q, theta_q;
    logic [IW-1:0]   id_q;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            accept_en;
    logic            xfer;
    logic            zero_vec;
    logic [W-1:0]    win_x, win_y;
    logic [IW-1:0]   ptr_next;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // The RESP cycle doubles as an arbitration slot so that a new request can be
    // taken on the edge that retires the response: one result per SETTLE+1 cycles.
    assign accept_en = !rst && ((state_q == IDLE) || (state_q == RESP));
    assign xfer      = accept_en && pick_any;
    assign win_x     = req_x[int'(pick_idx)*W +: W];
    assign win_y     = req_y[int'(pick_idx)*W +: W];
    assign ptr_next  = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);

`ifdef ATAN_ZERO_CHK_EN
    assign zero_vec = (win_x == '0) && (win_y == '0);
`else
    assign zero_vec = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = zero_vec ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (xfer) begin
                    state_d = zero_vec ? RESP : ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, settle counter, theta capture, response id.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            cnt_q    <= '0;
            core_x_q <= '0;
            core_y_q <= '0;
            theta_q  <= '0;
            id_q     <= '0;
        end else if (xfer) begin
            ptr_q <= ptr_next;
            id_q  <= pick_idx;
            cnt_q <= CW'(SETTLE - 1);
            if (zero_vec) begin
                theta_q <= '0;
            end else begin
                core_x_q <= win_x;
                core_y_q <= win_y;
            end
        end else if (state_q == ISSUE) begin
            if (cnt_q == '0) begin
                theta_q <= core_theta;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

`ifdef ATAN_ZERO_CHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (xfer) begin
            err_q <= zero_vec;
        end
    end
`endif

    // Outputs
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = 1'b0;
        rsp_err   = 1'b0;
        if (accept_en) begin
            req_ready = pick_gnt;
        end
        if (!rst) begin
            busy = (state_q != IDLE);
            if (state_q == RESP) begin
                rsp_valid[id_q] = 1'b1;
`ifdef ATAN_ZERO_CHK_EN
                rsp_err = err_q;
`endif
            end
        end
    end

    assign core_x    = core_x_q;
    assign core_y    = core_y_q;
    assign rsp_theta = theta_q;
    assign rsp_id    = id_q;

endmodule
